// File: rtl/time_unit_cnt.sv
// Cascadable modulo-MOD up/down counter for one digital-clock stage.
// Provides a same-cycle carry, two-digit BCD, and an optional 12-hour AM/PM view.
module time_unit_cnt #(
  parameter int unsigned MOD       = 24,
  parameter int unsigned W         = 7,
  parameter int unsigned HOUR_MODE = 0
) (
  input  logic         inclk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         mode12,
  output logic [W-1:0] cnt_out,
  output logic         carry,
  output logic         load_err,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones,
  output logic         pm
);

  localparam logic [W-1:0] CNT_MAX = W'(MOD - 1);
  localparam logic [W:0]   MOD_EXT = (W+1)'(MOD);

  logic [W-1:0] r_cnt;
  logic         r_load_err;

  logic         w_load_ok;
  logic         w_at_max;
  logic         w_at_min;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;

  assign w_load_ok = ({1'b0, load_val} < MOD_EXT);
  assign w_at_max  = (r_cnt == CNT_MAX);
  assign w_at_min  = (r_cnt == '0);
  assign w_inc     = w_at_max ? '0 : r_cnt + W'(1);
  assign w_dec     = w_at_min ? CNT_MAX : r_cnt - W'(1);

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge inclk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (load) begin
        if (w_load_ok) r_cnt <= load_val;
        else           r_load_err <= 1'b1;
      end else if (en) begin
        r_cnt <= up ? w_inc : w_dec;
      end
    end
  end

  assign cnt_out  = r_cnt;
  assign load_err = r_load_err;
  // Carry looks at en so a whole chain wraps on the same edge.
  assign carry    = en & ~load & (up ? w_at_max : w_at_min);

  // Display value; the count never exceeds 99, so 7 bits hold it.
  logic [6:0] w_cnt7;
  logic [6:0] w_disp;
  logic       w_pm;

  assign w_cnt7 = 7'(r_cnt);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_disp = w_cnt7;
    w_pm   = 1'b0;
    if ((HOUR_MODE != 0) && mode12) begin
      w_pm = (w_cnt7 >= 7'd12);
      if (w_cnt7 == 7'd0)       w_disp = 7'd12;
      else if (w_cnt7 > 7'd12)  w_disp = w_cnt7 - 7'd12;
    end
  end

  assign pm = w_pm;

  // Fixed-depth subtract-10 ladder: nine steps cover 0..99.
  logic [6:0] w_rem;
  logic [3:0] w_tens;

  always_comb begin
    w_rem  = w_disp;
    w_tens = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (w_rem >= 7'd10) begin
        w_rem  = w_rem - 7'd10;
        w_tens = w_tens + 4'd1;
      end
    end
  end

  assign bcd_tens = w_tens;
  assign bcd_ones = 4'(w_rem);

endmodule

// File: doc/time_unit_cnt.md
# time_unit_cnt

Parametrised, cascadable time-unit counter for the digital clock: one instance each for seconds, minutes and hours (MOD = 60/60/24). It counts up or down modulo MOD on enabled inclk edges, supports synchronous preset for time-setting, and produces a carry for the next stage. It also provides two-digit BCD for the display decoders, with an optional 12-hour AM/PM view for the hour stage. The count output is the live state, with no one-cycle output lag.

## Interface
- MOD, 24, modulus; count range 0..MOD-1; legal 2..100
- W, 7, width of cnt_out and load_val; must satisfy 2^W >= MOD
- HOUR_MODE, 0, 1 enables the 12-hour display logic (mode12, pm); 0 ties it off
- inclk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  count enable / carry-in from lower stage; one step per inclk edge while high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous preset strobe
- load_val  in  W  preset value
- mode12  in  1  display mode: 1 = 12-hour, 0 = 24-hour; ignored when HOUR_MODE=0
- cnt_out  out  W  current count, registered
- carry  out  1  terminal-count carry to the next stage (combinational)
- load_err  out  1  one-cycle pulse: preset value was out of range
- bcd_tens  out  4  display tens digit
- bcd_ones  out  4  display ones digit
- pm  out  1  PM indicator in 12-hour mode; 0 otherwise

## Operation
- Registered state consists of cnt_out and load_err only. All other outputs are combinational from cnt_out, en, up and mode12.
- Per-edge priority is load > en > hold.
  - load=1, load_val < MOD: cnt_out <= load_val, load_err <= 0. en is ignored that edge.
  - load=1, load_val >= MOD: cnt_out holds, load_err <= 1. en is ignored that edge.
  - load=0, en=1, up=1: cnt_out <= (cnt_out == MOD-1) ? 0 : cnt_out+1.
  - load=0, en=1, up=0: cnt_out <= (cnt_out == 0) ? MOD-1 : cnt_out-1.
  - Otherwise: cnt_out holds, load_err <= 0.
- carry = en & ~load & (up ? cnt_out == MOD-1 : cnt_out == 0). A stage's carry drives the next stage's en, so all stages in a chain wrap on the same edge.
- Display value D:
  - HOUR_MODE=0 or mode12=0: D = cnt_out, pm = 0.
  - HOUR_MODE=1 and mode12=1 (requires MOD=24):
    - cnt 0 → D=12, pm=0
    - cnt 1..11 → D=cnt, pm=0
    - cnt 12 → D=12, pm=1
    - cnt 13..23 → D=cnt-12, pm=1
- bcd_tens = D/10 and bcd_ones = D%10, both always 0..9. Use a constant-bound conversion: subtract-10 ladder or lookup; no generic divider.
- mode12 changes only the display. It never alters cnt_out.

## Timing
- Reset (rst=0, asynchronous): cnt_out=0, load_err=0.
  - carry = en & ~up while in reset; the bench holds en=0 during reset.
  - Display in 24-hour mode: bcd=0/0, pm=0.
  - Display in 12-hour mode: bcd=1/2, pm=0.
- Reset release is synchronous to inclk. The first counting edge is the first rising edge with rst=1.
- Count latency: one edge. cnt_out reflects a step or preset right after the inclk edge where en or load was sampled.
- carry, bcd_* and pm follow cnt_out combinationally within the same cycle.
- load_err is high for exactly the one cycle after the offending edge.
- Boundary cases:
  - Wrap up: MOD-1 → 0 with carry=1 in the cycle before the edge.
  - Wrap down: 0 → MOD-1 with carry=1.
  - en held high: steps every edge; carry is high exactly 1 cycle in MOD.
  - load and en both high: load wins; carry is 0 that cycle.
  - up toggled mid-count: takes effect on the next edge; no glitch on cnt_out.
  - rst asserted mid-count: outputs are forced to reset values immediately, without waiting for an edge.

## Test plan
- Reset/count, MOD=24, up=1, en=1: from reset, 24 edges give 0,1,…,23,0. carry is high only while cnt=23. bcd shows 2/3 at cnt=23.
- Down-count wrap, MOD=60, up=0, en=1, starting at 0: next edge gives 59 with carry=1 in the prior cycle; bcd=5/9.
- Preset: load=1, load_val=17, en=1 gives cnt=17 and no step. Then load_val=24 at MOD=24 gives cnt holds at 17 and load_err=1 for exactly one cycle.
- 12-hour view, HOUR_MODE=1, mode12=1:
  - cnt 0 → 1/2, pm=0
  - cnt 12 → 1/2, pm=1
  - cnt 13 → 0/1, pm=1
  - cnt 23 → 1/1, pm=1
  - Toggle mode12=0 at cnt 23: display 2/3 with cnt unchanged.
- Cascade: chain sec(60)→min(60)→hour(24), preset to 23:59:59, one enabled edge → 00:00:00, all three carries high the cycle before.
- Async reset mid-count: drop rst with cnt=9 between edges → cnt_out=0 and load_err=0 immediately. Release rst with en=1 → next edge gives 1.
